// File: rtl/cp0_exception_unit_if.sv
// rtl/cp0_exception_unit_if.sv - CP0 exception unit pipeline-side bus
//
// Groups every pipeline-facing signal of cp0_exception_unit.
// clk and reset are not carried here.
//   A1/A2/DIn/WE  mfc0 read number, mtc0 write number, data and enable
//   PC/BD         M-stage PC and branch-delay-slot flag
//   ExcCode/VAddr exception code (0 = none) and faulting data address
//   HWInt         level-sensitive hardware interrupt lines
//   EXLClr        eret at M stage
//   IntReq/EPC    redirect request and handler return address
//   DOut          mfc0 read data
// Modports: master = CPU pipeline side, slave = CP0 side.
interface cp0_exception_unit_if #(
    parameter int NUM_HWINT = 6
);
    logic [4:0]           A1;
    logic [4:0]           A2;
    logic [31:0]          DIn;
    logic                 WE;
    logic [31:0]          PC;
    logic                 BD;
    logic [4:0]           ExcCode;
    logic [31:0]          VAddr;
    logic [NUM_HWINT-1:0] HWInt;
    logic                 EXLClr;
    logic                 IntReq;
    logic [31:0]          EPC;
    logic [31:0]          DOut;

    modport master (
        output A1, A2, DIn, WE, PC, BD, ExcCode, VAddr, HWInt, EXLClr,
        input  IntReq, EPC, DOut
    );

    modport slave (
        input  A1, A2, DIn, WE, PC, BD, ExcCode, VAddr, HWInt, EXLClr,
        output IntReq, EPC, DOut
    );
endinterface

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - Coprocessor-0 exception/interrupt unit (SR, Cause, EPC, PRId)
//
// Arbitrates exceptions against hardware interrupts at the M stage, raises
// IntReq combinationally, latches SR/Cause/EPC and serves mfc0/mtc0/eret.
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  synchronous, active-high
//   bus    cp0_exception_unit_if.slave (pipeline-side signals)
// Optional build macro: CP0_BADVADDR_EN adds BadVAddr (reg 8), loaded on
// address-error exceptions (AdEL=4, AdES=5); otherwise reg 8 reads 0.
// NUM_HWINT must be 6: the lines map onto the fixed IP/IM field [15:10].
module cp0_exception_unit #(
    parameter logic [31:0] PRID_VAL  = 32'h0019_0305,
    parameter int          NUM_HWINT = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    cp0_exception_unit_if.slave     bus
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // SR fields
    logic [NUM_HWINT-1:0] im;
    logic                 exl;
    logic                 ie;
    // Cause fields
    logic                 cause_bd;
    logic [NUM_HWINT-1:0] ip;
    logic [4:0]           cause_exc;
    logic [31:0]          epc_q;

    logic                 int_pend;
    logic                 exc_pend;
    logic                 int_req;
    logic [31:0]          pc_word;
    logic [31:0]          epc_next;
    logic [31:0]          sr_val;
    logic [31:0]          cause_val;

    // EXL masks both sources, so a handler is never re-entered.
    assign int_pend = (|(bus.HWInt & im)) & ie & ~exl;
    assign exc_pend = (bus.ExcCode != 5'd0) & ~exl;
    assign int_req  = int_pend | exc_pend;

    // A delay-slot instruction restarts at its branch, one word earlier.
    assign pc_word  = {bus.PC[31:2], 2'b00};
    assign epc_next = bus.BD ? (pc_word - 32'd4) : pc_word;

    assign sr_val    = {16'b0, im, 8'b0, exl, ie};
    assign cause_val = {cause_bd, 15'b0, ip, 3'b0, cause_exc, 2'b0};

    assign bus.IntReq = int_req;
    assign bus.EPC    = epc_q;

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            badvaddr_q <= 32'd0;
        end else if (exc_pend && !int_pend &&
                     (bus.ExcCode == EXC_ADEL || bus.ExcCode == EXC_ADES)) begin
            badvaddr_q <= bus.VAddr;
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.PC[1:0]};
`else
    logic [31:0] badvaddr_q;
    assign badvaddr_q = 32'd0;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.PC[1:0], bus.VAddr, EXC_ADEL, EXC_ADES};
`endif

    // Read path sees register state only: a same-cycle mtc0 is not forwarded.
    always_comb begin
        bus.DOut = 32'd0;
        case (bus.A1)
            REG_BADVADDR: bus.DOut = badvaddr_q;
            REG_SR:       bus.DOut = sr_val;
            REG_CAUSE:    bus.DOut = cause_val;
            REG_EPC:      bus.DOut = epc_q;
            REG_PRID:     bus.DOut = PRID_VAL;
            default:      bus.DOut = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im        <= '0;
            exl       <= 1'b0;
            ie        <= 1'b0;
            cause_bd  <= 1'b0;
            ip        <= '0;
            cause_exc <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            ip <= bus.HWInt;
            if (int_req) begin
                // Taking an exception/interrupt overrides both mtc0 and eret.
                exl       <= 1'b1;
                cause_exc <= int_pend ? 5'd0 : bus.ExcCode;
                cause_bd  <= bus.BD;
                epc_q     <= epc_next;
            end else begin
                if (bus.WE) begin
                    if (bus.A2 == REG_SR) begin
                        im  <= bus.DIn[15:10];
                        exl <= bus.DIn[1];
                        ie  <= bus.DIn[0];
                    end else if (bus.A2 == REG_EPC) begin
                        epc_q <= {bus.DIn[31:2], 2'b00};
                    end
                end
                if (bus.EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end
endmodule
